int_div_seq: RTL and testbench

//  Multi-cycle signed/unsigned integer divider producing quotient and remainder of two WIDTH-bit operands.

---
 rtl/int_div_pkg.sv | 17 +
 rtl/int_div_step.sv | 23 ++
 rtl/int_div_seq.sv | 141 ++++++++++++++
 tb/tb_int_div_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_div_pkg.sv
// Shared types and helpers for the sequential integer divider.
package int_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Width of the iteration counter that counts WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/int_div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit, trial-subtract the divisor.
module int_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // With i_rem < i_dsr the shifted value is below 2*i_dsr, so the borrow bit alone decides the quotient bit.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {1'b0, i_dsr};
    o_q     = ~w_diff[WIDTH];
    o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/int_div_seq.sv
// Multi-cycle signed/unsigned integer divider with valid/ready handshakes; one divide in flight.
module int_div_seq
  import int_div_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;      // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rmd;
  logic             r_dbz;

  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_mag_nxt;
  logic             w_in_ready;
  logic             w_out_valid;

  // The unsigned WIDTH-bit magnitude of the most-negative value is exact, so no wider operand path is needed.
  always_comb begin
    w_dvd_neg   = SIGNED && dividend[WIDTH-1];
    w_dsr_neg   = SIGNED && divisor[WIDTH-1];
    w_dvd_mag   = w_dvd_neg ? -dividend : dividend;
    w_dsr_mag   = w_dsr_neg ? -divisor : divisor;
    w_q_mag_nxt = {r_dvd[WIDTH-2:0], w_q_bit};
  end

  int_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[WIDTH-1]),
    .i_dsr (r_dsr),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_bit)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = (divisor == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (r_cnt == CNT_W'(0)) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              r_quot <= '1;
              r_rmd  <= dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_dvd   <= w_dvd_mag;
              r_dsr   <= w_dsr_mag;
              r_rem   <= '0;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_neg_q <= w_dvd_neg ^ w_dsr_neg;
              r_neg_r <= w_dvd_neg;
            end
          end
        end
        BUSY: begin
          r_dvd <= w_q_mag_nxt;
          r_rem <= w_rem_nxt;
          if (r_cnt != CNT_W'(0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // Sign fixup on the final step: most-negative / -1 wraps naturally to most-negative.
            r_quot <= r_neg_q ? -w_q_mag_nxt : w_q_mag_nxt;
            r_rmd  <= r_neg_r ? -w_rem_nxt : w_rem_nxt;
            r_dbz  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) r_dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign quotient    = r_quot;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_int_div_seq.sv
// Directed bench for int_div_seq: a signed and an unsigned instance checked against an arithmetic model.
module tb_int_div_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  logic reset;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_dbz;
  logic [W-1:0] s_dividend, s_divisor, s_q, s_r;
  logic         u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_dbz;
  logic [W-1:0] u_dividend, u_divisor, u_q, u_r;

  int n_cmp = 0;
  int n_err = 0;

  res_t exp_s[$];
  res_t exp_u[$];

  always #5 clk = ~clk;

  int_div_seq #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .dividend(s_dividend), .divisor(s_divisor),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .quotient(s_q), .remainder(s_r), .div_by_zero(s_dbz)
  );

  int_div_seq #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .reset(reset),
    .in_valid(u_in_valid), .in_ready(u_in_ready),
    .dividend(u_dividend), .divisor(u_divisor),
    .out_valid(u_out_valid), .out_ready(u_out_ready),
    .quotient(u_q), .remainder(u_r), .div_by_zero(u_dbz)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Verilog integer division semantics, written directly in terms of the language operators.
  function automatic res_t model(input bit uns, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else if (uns) begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = '0; e.z = 1'b0;
    end else begin
      e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.z = 1'b0;
    end
    return e;
  endfunction

  // Compare process: whenever a result is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (s_out_valid) begin
        if (exp_s.size() == 0) check("s_unexpected_result", 1, 0);
        else begin
          check("s_quotient", s_q, exp_s[0].q);
          check("s_remainder", s_r, exp_s[0].r);
          check("s_div_by_zero", s_dbz, exp_s[0].z);
          check("s_in_ready_busy", s_in_ready, 0);
          if (s_out_ready) void'(exp_s.pop_front());
        end
      end
      if (u_out_valid) begin
        if (exp_u.size() == 0) check("u_unexpected_result", 1, 0);
        else begin
          check("u_quotient", u_q, exp_u[0].q);
          check("u_remainder", u_r, exp_u[0].r);
          check("u_div_by_zero", u_dbz, exp_u[0].z);
          check("u_in_ready_busy", u_in_ready, 0);
          if (u_out_ready) void'(exp_u.pop_front());
        end
      end
    end
  end

  // Issue one divide, hold out_ready low for 'hold' cycles, return what the DUT presented.
  task automatic run_op(input bit uns, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z, output int lat);
    res_t e;
    bit   seen;
    e = model(uns, a, b);
    if (uns) begin
      check("u_in_ready_idle", u_in_ready, 1);
      u_dividend = a; u_divisor = b; u_in_valid = 1'b1; u_out_ready = (hold == 0);
    end else begin
      check("s_in_ready_idle", s_in_ready, 1);
      s_dividend = a; s_divisor = b; s_in_valid = 1'b1; s_out_ready = (hold == 0);
    end
    @(posedge clk);
    if (uns) exp_u.push_back(e); else exp_s.push_back(e);
    #1;
    u_in_valid = 1'b0;
    s_in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (uns ? u_out_valid : s_out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!seen) check("result_timeout", 0, 1);
    q = uns ? u_q : s_q;
    r = uns ? u_r : s_r;
    z = uns ? u_dbz : s_dbz;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      check("held_valid", uns ? u_out_valid : s_out_valid, 1);
      if (uns) u_out_ready = 1'b1; else s_out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("idle_after_hs_ready", uns ? u_in_ready : s_in_ready, 1);
    check("idle_after_hs_valid", uns ? u_out_valid : s_out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q, r;
    logic         z;
    int           lat;
    logic [W-1:0] vec_a[8] = '{32'd0, 32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                               32'd123456789, 32'hFFFF_FF9C, 32'h8000_0000};
    logic [W-1:0] vec_b[8] = '{32'd5, 32'd7, 32'd1, 32'd1, 32'hFFFF_FFFF,
                               32'hFFFF_FC18, 32'hFFFF_FFF9, 32'd2};

    reset = 1'b1;
    s_in_valid = 0; s_out_ready = 1; s_dividend = 0; s_divisor = 0;
    u_in_valid = 0; u_out_ready = 1; u_dividend = 0; u_divisor = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_s_in_ready", s_in_ready, 1);
    check("rst_s_out_valid", s_out_valid, 0);
    check("rst_s_quotient", s_q, 0);
    check("rst_s_remainder", s_r, 0);
    check("rst_s_dbz", s_dbz, 0);
    check("rst_u_in_ready", u_in_ready, 1);
    check("rst_u_out_valid", u_out_valid, 0);

    run_op(0, 32'd36, 32'd4, 0, q, r, z, lat);
    check("t36_4_q", q, 32'd9);
    check("t36_4_r", r, 32'd0);
    check("t36_4_latency", lat, W + 1);
    check("t36_4_downstream", q + 32'd1, 32'h0000_000A);

    run_op(0, 32'hFFFF_FFF9, 32'd2, 0, q, r, z, lat);
    check("tm7_2_q", q, 32'hFFFF_FFFD);
    check("tm7_2_r", r, 32'hFFFF_FFFF);

    run_op(0, 32'd7, 32'hFFFF_FFFE, 0, q, r, z, lat);
    check("t7_m2_q", q, 32'hFFFF_FFFD);
    check("t7_m2_r", r, 32'd1);

    run_op(1, 32'hFFFF_FFF9, 32'd2, 0, q, r, z, lat);
    check("u_fff9_2_q", q, 32'h7FFF_FFFC);
    check("u_fff9_2_r", r, 32'd1);

    run_op(0, 32'd7, 32'd0, 0, q, r, z, lat);
    check("t7_0_q", q, 32'hFFFF_FFFF);
    check("t7_0_r", r, 32'd7);
    check("t7_0_dbz", z, 1);
    check("t7_0_latency", lat, 1);

    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, q, r, z, lat);
    check("ovf_q", q, 32'h8000_0000);
    check("ovf_r", r, 32'd0);
    check("ovf_dbz", z, 0);

    // Backpressure: -100/7 held for 10 cycles, then an immediate follow-up divide.
    run_op(0, 32'hFFFF_FF9C, 32'd7, 10, q, r, z, lat);
    check("bp_q", q, 32'hFFFF_FFF2);
    check("bp_r", r, 32'hFFFF_FFFE);
    run_op(0, 32'd5, 32'd5, 0, q, r, z, lat);
    check("after_bp_q", q, 32'd1);

    for (int i = 0; i < 8; i++) run_op(0, vec_a[i], vec_b[i], 0, q, r, z, lat);
    run_op(1, 32'hFFFF_FFFF, 32'd1, 0, q, r, z, lat);
    run_op(1, 32'h8000_0000, 32'd0, 0, q, r, z, lat);
    check("u_div0_dbz", z, 1);
    run_op(1, 32'd10, 32'd3, 2, q, r, z, lat);
    check("u_10_3_q", q, 32'd3);
    check("u_10_3_r", r, 32'd1);

    // Abort during the fifth BUSY cycle.
    s_dividend = 32'd1000; s_divisor = 32'd3; s_in_valid = 1'b1; s_out_ready = 1'b1;
    @(posedge clk); #1 s_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_s.delete();
    check("abort_in_ready", s_in_ready, 1);
    check("abort_out_valid", s_out_valid, 0);
    check("abort_quotient", s_q, 0);
    check("abort_remainder", s_r, 0);
    check("abort_dbz", s_dbz, 0);

    run_op(0, 32'd100, 32'd10, 0, q, r, z, lat);
    check("post_abort_q", q, 32'd10);
    check("post_abort_r", r, 32'd0);

    repeat (3) @(posedge clk);
    check("s_queue_drained", exp_s.size(), 0);
    check("u_queue_drained", exp_u.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
